uart_echo_bridge: RTL and testbench
===================================

Name: uart_echo_bridge

Overview:
- Parametrised RX-to-TX relay core for the UART loopback path, placed between a SIPO-style receiver and a PISO-style transmitter.
- Replaces the single-register, drop-if-busy relay with:
  - a DEPTH-entry FIFO,
  - a handshaked TX launch state machine,
  - an optional CR -> CR LF expansion,
  - an error-byte policy,
  - saturating overflow and error statistics.
- All logic is in the single clk domain. rx_valid and tx_done arrive as one-cycle pulses that are already synchronous to clk.

Parameters:
- WIDTH, 8: data byte width.
- DEPTH, 16: FIFO entries; must be a power of two, 2..256.
- CRLF_EXPAND, 0: when 1, each transmitted byte equal to 8'h0D is followed by 8'h0A (valid only for WIDTH=8).
- ERR_POLICY, 0: on rx_error, 0 = drop the byte; 1 = enqueue ERR_BYTE instead.
- ERR_BYTE, 8'h3F: substitute byte ('?') used when ERR_POLICY=1.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  0 = FIFO accepts but TX launch is held; an in-flight byte still completes
- clear_stats  in  1  synchronous clear of err_count, ovf_count, overflow
- rx_data  in  WIDTH  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_error  in  1  framing/parity error, qualified by rx_valid
- tx_active  in  1  transmitter busy
- tx_done  in  1  one-cycle strobe, byte fully shifted out
- tx_data  out  WIDTH  byte to transmit, stable from the tx_load cycle until tx_done
- tx_load  out  1  one-cycle launch strobe
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky, set when a byte is lost to a full FIFO
- ovf_count  out  CNT_W  saturating count of lost bytes
- err_count  out  CNT_W  saturating count of rx_error strobes

Behaviour:
- Reset values: tx_data=0, tx_load=0, fifo_count=0, overflow=0, ovf_count=0, err_count=0, FSM=IDLE, lf_pending=0. Reset mid-transmission abandons the byte and empties the FIFO; tx_load is never asserted in the reset cycle.
- Push (cycle of rx_valid):
  - rx_error=0: push rx_data.
  - rx_error=1 and ERR_POLICY=0: no push.
  - rx_error=1 and ERR_POLICY=1: push ERR_BYTE.
  - Any rx_error=1: err_count increments, saturating at 2^CNT_W-1.
- Full FIFO, push attempted:
  - With no pop in the same cycle: byte discarded, overflow<=1, ovf_count increments (saturating).
  - With a pop in the same cycle: push accepted, no overflow.
- Pointers wrap modulo DEPTH. fifo_count is updated in the cycle after push/pop.
- FSM states and transitions:
  - IDLE: if enable && fifo_count!=0, pop the head into tx_data and go to LAUNCH.
  - LAUNCH: tx_load=1 for exactly this cycle; go to WAIT_ACT.
  - WAIT_ACT: wait for tx_active=1, then go to WAIT_DONE. If tx_done arrives first, treat it as WAIT_DONE completion.
  - WAIT_DONE: on tx_done:
    - If CRLF_EXPAND && tx_data==8'h0D && !lf_pending: tx_data<=8'h0A, lf_pending<=1, go to LAUNCH.
    - Otherwise lf_pending<=0, go to IDLE.
- The inserted LF consumes no FIFO entry.
- Latency:
  - Byte pushed into an empty FIFO with the FSM in IDLE: tx_load asserts 2 cycles after rx_valid (fifo_count visible, then pop -> LAUNCH).
  - Back-to-back bytes: tx_load asserts 2 cycles after tx_done.
- enable deassert in WAIT_ACT or WAIT_DONE does not abort; the FSM returns to IDLE and holds there. A pending LF is still sent.
- clear_stats has priority over a simultaneous increment (counter becomes 0). It does not affect the FIFO.
- A simultaneous rx_valid and tx_done are independent: both are processed in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, LAUNCH, WAIT_ACT, WAIT_DONE);
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_QMARK=8'h3F;
  - a saturating-increment function.
- One sub-module, sync_fifo (WIDTH, DEPTH):
  - ports push, pop, din, dout, full, empty, count;
  - first-word-fall-through, synchronous active-high rst.
- The FSM and counters stay in uart_echo_bridge.

Test Plan:
- Push 8'hA5 into an empty FIFO, tx model asserts tx_active 1 cycle after tx_load and tx_done 10 cycles later -> tx_load pulses once 2 cycles after rx_valid, tx_data=8'hA5 until tx_done, fifo_count returns to 0.
- Burst-push 20 bytes 0x00..0x13 while tx_active is stuck high (DEPTH=16) -> FIFO holds 0x00..0x0F (no pop occurs, since the FSM is parked in WAIT_DONE), overflow=1, ovf_count=4; after releasing the model, the bytes transmit in order 0x00..0x0F.
- CRLF_EXPAND=1, push 8'h0D then 8'h41 -> TX sequence 0D, 0A, 41, with exactly three tx_load pulses.
- rx_valid with rx_error=1 and rx_data=8'h55:
  - ERR_POLICY=0: no transmission, err_count=1.
  - ERR_POLICY=1: transmits 8'h3F, err_count=1.
- Full FIFO with a push in the same cycle as a pop (FSM in IDLE) -> no overflow, fifo_count stays 16.
- Assert rst during WAIT_DONE with 5 bytes queued -> next cycle all outputs at reset values; a later tx_done is ignored; fresh traffic behaves normally.

Source files
------------

// File: rtl/uart_echo_bridge_pkg.sv
// Shared types and helpers for the UART echo path.
// Holds the TX launch FSM state encoding and ASCII constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_ACT,
        WAIT_DONE
    } tx_state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] max
    );
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/uart_echo_bridge_if.sv
// RX/TX byte handshake bundle between receiver, bridge and transmitter.
// master is the bridge side, slave is the PHY side.
interface uart_echo_bridge_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_error;
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic             tx_active;
    logic             tx_done;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  rx_error,
        input  tx_active,
        input  tx_done,
        output tx_data,
        output tx_load
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output rx_error,
        output tx_active,
        output tx_done,
        input  tx_data,
        input  tx_load
    );
endinterface

// File: rtl/uart_echo_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered occupancy.
// A push into a full FIFO is taken only when a pop frees a slot.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_bridge.sv
// RX-to-TX relay: FIFO buffering, handshaked TX launch, optional
// CR->CRLF expansion, error-byte policy and saturating statistics.
module uart_echo_bridge
    import uart_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 16,
    parameter int               CRLF_EXPAND = 0,
    parameter int               ERR_POLICY  = 0,
    parameter logic [WIDTH-1:0] ERR_BYTE    = 8'h3F,
    parameter int               CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear_stats,
    uart_echo_bridge_if.master       bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [CNT_W-1:0]         err_count
);

    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    tx_state_t        state;
    logic             lf_pending;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             empty;
    logic             lost;
    logic             add_lf;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] head;

    assign push_req  = bus.rx_valid && (!bus.rx_error || ERR_POLICY != 0);
    assign push_data = bus.rx_error ? ERR_BYTE : bus.rx_data;
    assign pop       = (state == IDLE) && enable && !empty;
    assign lost      = push_req && full && !pop;
    assign add_lf    = (CRLF_EXPAND != 0)
                    && (bus.tx_data == WIDTH'(ASCII_CR))
                    && !lf_pending;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (push_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // tx_load is registered: it is set on entry to LAUNCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.tx_data <= '0;
            bus.tx_load <= 1'b0;
            lf_pending  <= 1'b0;
        end else begin
            bus.tx_load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        bus.tx_data <= head;
                        bus.tx_load <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_ACT;
                end
                WAIT_ACT, WAIT_DONE: begin
                    if (bus.tx_done) begin
                        if (add_lf) begin
                            bus.tx_data <= WIDTH'(ASCII_LF);
                            bus.tx_load <= 1'b1;
                            lf_pending  <= 1'b1;
                            state       <= LAUNCH;
                        end else begin
                            lf_pending <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (state == WAIT_ACT && bus.tx_active) begin
                        state <= WAIT_DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
            err_count <= '0;
        end else begin
            if (lost) begin
                overflow  <= 1'b1;
                ovf_count <= CNT_W'(sat_inc(32'(ovf_count), CNT_MAX));
            end
            if (bus.rx_valid && bus.rx_error) begin
                err_count <= CNT_W'(sat_inc(32'(err_count), CNT_MAX));
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_bridge.sv
// Scoreboard bench: u0 is the default build, u1 has CR->CRLF expansion
// and error-byte substitution enabled.
module tb_uart_echo_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en0, en1, clr;
    logic       hold0, hold1;
    logic       busy0, busy1;
    logic [4:0] fc0, fc1;
    logic       ovf0, ovf1;
    logic [7:0] oc0, oc1, ec0, ec1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         ldc0 = 0;
    int         ldc1 = 0;

    uart_echo_bridge_if #(.WIDTH(8)) bus0 ();
    uart_echo_bridge_if #(.WIDTH(8)) bus1 ();

    uart_echo_bridge #(
        .WIDTH(8), .DEPTH(16), .CRLF_EXPAND(0),
        .ERR_POLICY(0), .ERR_BYTE(8'h3F), .CNT_W(8)
    ) u0 (
        .clk(clk), .rst(rst), .enable(en0), .clear_stats(clr),
        .bus(bus0), .fifo_count(fc0), .overflow(ovf0),
        .ovf_count(oc0), .err_count(ec0)
    );

    uart_echo_bridge #(
        .WIDTH(8), .DEPTH(16), .CRLF_EXPAND(1),
        .ERR_POLICY(1), .ERR_BYTE(8'h3F), .CNT_W(8)
    ) u1 (
        .clk(clk), .rst(rst), .enable(en1), .clear_stats(clr),
        .bus(bus1), .fifo_count(fc1), .overflow(ovf1),
        .ovf_count(oc1), .err_count(ec1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_load(input int sel);
        return (sel == 0) ? bus0.tx_load : bus1.tx_load;
    endfunction

    function automatic logic [7:0] get_txd(input int sel);
        return (sel == 0) ? bus0.tx_data : bus1.tx_data;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? bus0.tx_done : bus1.tx_done;
    endfunction

    function automatic logic get_act(input int sel);
        return (sel == 0) ? bus0.tx_active : bus1.tx_active;
    endfunction

    function automatic logic get_hold(input int sel);
        return (sel == 0) ? hold0 : hold1;
    endfunction

    task automatic set_act(input int sel, input logic v);
        if (sel == 0) bus0.tx_active = v;
        else          bus1.tx_active = v;
    endtask

    task automatic set_done(input int sel, input logic v);
        if (sel == 0) bus0.tx_done = v;
        else          bus1.tx_done = v;
    endtask

    task automatic set_busy(input int sel, input logic v);
        if (sel == 0) busy0 = v;
        else          busy1 = v;
    endtask

    task automatic exp_push(input int sel, input logic [7:0] d);
        if (sel == 0) q0.push_back(d);
        else          q1.push_back(d);
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    // Transmitter: tx_active one cycle after tx_load, tx_done 10 later
    task automatic tx_model(input int sel);
        int ph  = 0;
        int cnt = 0;
        forever begin
            @(negedge clk);
            set_done(sel, 1'b0);
            if (ph == 0) begin
                if (get_load(sel) && !rst) begin
                    ph = 1;
                    set_busy(sel, 1'b1);
                end else begin
                    set_busy(sel, 1'b0);
                end
            end else if (ph == 1) begin
                set_act(sel, 1'b1);
                cnt = 10;
                ph  = 2;
            end else if (cnt > 1) begin
                cnt--;
            end else if (!get_hold(sel)) begin
                set_act(sel, 1'b0);
                set_done(sel, 1'b1);
                ph = 0;
            end
        end
    endtask

    task automatic monitor(input int sel);
        logic [7:0] last  = '0;
        logic [7:0] exp;
        bit         armed = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                armed = 1'b0;
            end else begin
                if (get_done(sel) && armed) begin
                    chk($sformatf("tx_data_stable%0d", sel), get_txd(sel), last);
                    armed = 1'b0;
                end
                if (get_load(sel)) begin
                    if (sel == 0) ldc0++;
                    else          ldc1++;
                    chk($sformatf("load_expected%0d", sel), qsize(sel) != 0, 1);
                    if (qsize(sel) != 0) begin
                        exp = (sel == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("tx_byte%0d", sel), get_txd(sel), exp);
                    end
                    last  = get_txd(sel);
                    armed = 1'b1;
                end
            end
        end
    endtask

    task automatic rx_send(input int sel, input logic [7:0] d, input logic e);
        if (sel == 0) begin
            bus0.rx_data = d; bus0.rx_error = e; bus0.rx_valid = 1'b1;
        end else begin
            bus1.rx_data = d; bus1.rx_error = e; bus1.rx_valid = 1'b1;
        end
        @(negedge clk);
        bus0.rx_valid = 1'b0; bus0.rx_error = 1'b0;
        bus1.rx_valid = 1'b0; bus1.rx_error = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        while (n < 3000 && !(qsize(sel) == 0 && !((sel == 0) ? busy0 : busy1)
               && ((sel == 0) ? fc0 : fc1) == 0)) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout%0d", sel), n < 3000, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_act(input int sel);
        int n = 0;
        while (n < 50 && !get_act(sel)) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("act_timeout%0d", sel), n < 50, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_tx_data"}, bus0.tx_data, 0);
        chk({tag, "_tx_load"}, bus0.tx_load, 0);
        chk({tag, "_fifo_count"}, fc0, 0);
        chk({tag, "_overflow"}, ovf0, 0);
        chk({tag, "_ovf_count"}, oc0, 0);
        chk({tag, "_err_count"}, ec0, 0);
    endtask

    initial tx_model(0);
    initial tx_model(1);
    initial monitor(0);
    initial monitor(1);

    initial begin
        int l;
        rst = 1'b1; en0 = 1'b1; en1 = 1'b1; clr = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0; busy0 = 1'b0; busy1 = 1'b0;
        bus0.rx_data = '0; bus0.rx_valid = 1'b0; bus0.rx_error = 1'b0;
        bus1.rx_data = '0; bus1.rx_valid = 1'b0; bus1.rx_error = 1'b0;
        bus0.tx_active = 1'b0; bus0.tx_done = 1'b0;
        bus1.tx_active = 1'b0; bus1.tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset0("por");
        rst = 1'b0;
        @(negedge clk);

        // Single byte, latency of two cycles to tx_load
        exp_push(0, 8'hA5);
        rx_send(0, 8'hA5, 1'b0);
        chk("t1_count", fc0, 1);
        chk("t1_no_early_load", bus0.tx_load, 0);
        @(negedge clk);
        chk("t1_load_latency", bus0.tx_load, 1);
        chk("t1_data", bus0.tx_data, 8'hA5);
        chk("t1_popped", fc0, 0);
        wait_idle(0);

        // Overflow burst while the transmitter is stuck busy
        hold0 = 1'b1;
        exp_push(0, 8'h77);
        rx_send(0, 8'h77, 1'b0);
        wait_act(0);
        for (int i = 0; i < 20; i++) begin
            bus0.rx_data  = 8'(i);
            bus0.rx_valid = 1'b1;
            if (i < 16) exp_push(0, 8'(i));
            @(negedge clk);
        end
        bus0.rx_valid = 1'b0;
        chk("t2_full_count", fc0, 16);
        chk("t2_overflow", ovf0, 1);
        chk("t2_ovf_count", oc0, 4);
        hold0 = 1'b0;
        wait_idle(0);

        // Clear stats, fill with TX held, then push and pop together
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t3_clr_overflow", ovf0, 0);
        chk("t3_clr_ovf_count", oc0, 0);
        en0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus0.rx_data  = 8'h20 + 8'(i);
            bus0.rx_valid = 1'b1;
            exp_push(0, 8'h20 + 8'(i));
            @(negedge clk);
        end
        bus0.rx_valid = 1'b0;
        @(negedge clk);
        chk("t3_held_full", fc0, 16);
        chk("t3_held_no_load", bus0.tx_load, 0);
        en0 = 1'b1;
        exp_push(0, 8'h30);
        rx_send(0, 8'h30, 1'b0);
        chk("t3_pushpop_count", fc0, 16);
        chk("t3_pushpop_no_ovf", ovf0, 0);
        chk("t3_pushpop_ovf_cnt", oc0, 0);
        wait_idle(0);

        // Error drop policy; clear_stats wins over a same-cycle increment
        clr = 1'b1;
        rx_send(0, 8'h55, 1'b1);
        clr = 1'b0;
        chk("t4_clr_priority", ec0, 0);
        rx_send(0, 8'h55, 1'b1);
        chk("t4_err_count", ec0, 1);
        chk("t4_dropped", fc0, 0);
        repeat (10) @(negedge clk);

        // CR followed by a byte expands to CR LF byte
        l = ldc1;
        exp_push(1, 8'h0D);
        exp_push(1, 8'h0A);
        exp_push(1, 8'h41);
        rx_send(1, 8'h0D, 1'b0);
        rx_send(1, 8'h41, 1'b0);
        wait_idle(1);
        chk("t5_load_pulses", ldc1 - l, 3);

        // Error substitution policy
        exp_push(1, 8'h3F);
        rx_send(1, 8'h55, 1'b1);
        chk("t6_err_count", ec1, 1);
        chk("t6_queued", fc1, 1);
        wait_idle(1);

        // Reset while parked in WAIT_DONE with 5 bytes queued
        hold0 = 1'b1;
        exp_push(0, 8'h50);
        rx_send(0, 8'h50, 1'b0);
        wait_act(0);
        for (int i = 1; i <= 5; i++) begin
            rx_send(0, 8'h50 + 8'(i), 1'b0);
        end
        chk("t7_queued", fc0, 5);
        l = ldc0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset0("t7_rst");
        @(negedge clk);
        rst = 1'b0;
        hold0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("t7_stale_done_ignored", ldc0 - l, 0);
        chk("t7_fifo_empty", fc0, 0);
        exp_push(0, 8'h66);
        rx_send(0, 8'h66, 1'b0);
        wait_idle(0);
        chk("t7_fresh_load", ldc0 - l, 1);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
